// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, lock-state encoding and coordinate helpers
// for the VGA sync decoder.
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned GOOD_CNT_W  = 3;

    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned H_ACT_END   = 784;
    localparam int unsigned V_ACT_START = 35;
    localparam int unsigned V_ACT_END   = 515;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // Increment that sticks at the top of the 10-bit range.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == COORD_MAX) ? v : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a sync input and flags its rising edge. The register resets high so
// a sync already asserted at reset release is not mistaken for an edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise_c
);

    logic q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b1;
        end else begin
            q <= sig;
        end
    end

    assign rise_c = sig & ~q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel coordinates and active-video from h_sync/v_sync, measures line
// and frame length, and tracks lock against the expected timing.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int unsigned H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int unsigned V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int unsigned V_ACT_END   = vga_timing_pkg::V_ACT_END,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] rec_x,
    output logic [9:0] rec_y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_tick,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    import vga_timing_pkg::*;

    localparam logic [COORD_W-1:0]    H_LAST      = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0]    H_TIMEOUT   = COORD_W'(H_TOTAL);
    localparam logic [COORD_W-1:0]    V_LAST      = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0]    HA_START    = COORD_W'(H_ACT_START);
    localparam logic [COORD_W-1:0]    HA_END      = COORD_W'(H_ACT_END);
    localparam logic [COORD_W-1:0]    VA_START    = COORD_W'(V_ACT_START);
    localparam logic [COORD_W-1:0]    VA_END      = COORD_W'(V_ACT_END);
    localparam logic [GOOD_CNT_W-1:0] LOCK_TARGET = GOOD_CNT_W'(LOCK_FRAMES);

    logic h_rise;
    logic v_rise;

    sync_edge_det u_h_edge (
        .clk    (clk),
        .rst    (rst),
        .sig    (h_sync),
        .rise_c (h_rise)
    );

    sync_edge_det u_v_edge (
        .clk    (clk),
        .rst    (rst),
        .sig    (v_sync),
        .rise_c (v_rise)
    );

    lock_state_t           state;
    logic [GOOD_CNT_W-1:0] good_cnt;
    logic [GOOD_CNT_W-1:0] good_next;
    logic                  line_err;
    logic                  timeout;
    logic                  frame_good;
    logic                  frame_err;
    logic                  any_err;

    // Timing checks evaluated against the coordinates reached before this edge.
    assign line_err   = h_rise && (rec_x != H_LAST);
    assign timeout    = !h_rise && (rec_x == H_TIMEOUT);
    assign frame_good = v_rise && h_rise && (rec_y == V_LAST);
    assign frame_err  = (v_rise && !frame_good) ||
                        (h_rise && !v_rise && (rec_y == V_LAST));
    assign any_err    = line_err || frame_err || timeout;
    assign good_next  = good_cnt + GOOD_CNT_W'(1);

    // Coordinate recovery and line/frame length measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_x       <= '0;
            rec_y       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            rec_x <= h_rise ? '0 : sat_inc(rec_x);
            if (v_rise) begin
                rec_y <= '0;
            end else if (h_rise) begin
                rec_y <= sat_inc(rec_y);
            end
            if (h_rise) begin
                line_len <= sat_inc(rec_x);
            end
            if (v_rise) begin
                frame_lines <= sat_inc(rec_y);
            end
        end
    end

    // Lock tracking; errors win over a good frame seen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNLOCKED;
            good_cnt   <= '0;
            locked     <= 1'b0;
            frame_tick <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            sync_err   <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (v_rise) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (timeout) begin
                        state <= UNLOCKED;
                    end else if (line_err || frame_err) begin
                        good_cnt <= '0;
                    end else if (frame_good) begin
                        good_cnt <= good_next;
                        if (good_next == LOCK_TARGET) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state    <= UNLOCKED;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end else if (frame_good) begin
                        frame_tick <= 1'b1;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign video_on = locked &&
                      (rec_x >= HA_START) && (rec_x < HA_END) &&
                      (rec_y >= VA_START) && (rec_y < VA_END);

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator: takes h_sync/v_sync on the pixel clock and rebuilds pixel coordinates and a video-active flag.
- Measures the line length and frame height, and reports lock against the expected timing.
- Used to check generator output in-system and to feed overlay/capture logic that sees only sync signals.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_ACT_START, 144, first active pixel column
- H_ACT_END, 784, first column after the active region
- V_ACT_START, 35, first active line
- V_ACT_END, 515, first line after the active region
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..7)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- h_sync  in  1  horizontal sync, active-high pulse; its rising edge marks column 0
- v_sync  in  1  vertical sync, active-high pulse; its rising edge, coincident with an h_sync rise, marks line 0
- rec_x  out  10  recovered column
- rec_y  out  10  recovered line
- video_on  out  1  recovered active-video flag
- locked  out  1  timing locked
- frame_tick  out  1  one-cycle pulse at the start of each good locked frame
- sync_err  out  1  one-cycle pulse when lock is lost
- line_len  out  10  length of the last complete line, in clocks
- frame_lines  out  10  line count of the last complete frame

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Edge registers h_q and v_q reset to 1, so a sync that is already high at reset release is not taken as an edge.
  - good_cnt = 0; state = UNLOCKED.
- Edge detection: h_rise = h_sync & ~h_q; v_rise = v_sync & ~v_q. Both h_q and v_q register their inputs every cycle.
- rec_x:
  - On h_rise, rec_x <= 0.
  - Otherwise rec_x <= rec_x + 1, saturating at 1023.
  - Result: rec_x is the generator's column delayed by exactly 1 clock.
- rec_y:
  - On h_rise & v_rise, rec_y <= 0.
  - On h_rise alone, rec_y <= rec_y + 1, saturating at 1023.
  - On v_rise alone, rec_y <= 0 (this is also a frame error).
- Measurement:
  - On h_rise, line_len <= rec_x + 1.
  - On v_rise, frame_lines <= rec_y + 1.
  - Both are 10-bit and saturate at 1023.
- Conditions checked by the state machine:
  - Line error: h_rise while rec_x != H_TOTAL-1.
  - Timeout: rec_x == H_TOTAL with no h_rise.
  - Frame good: v_rise & h_rise & rec_y == V_TOTAL-1.
  - Frame error: v_rise when the frame is not good; or h_rise & ~v_rise & rec_y == V_TOTAL-1.
- State machine (registered):
  - UNLOCKED: on v_rise, go to ACQUIRE with good_cnt = 0. No checks are made in this state.
  - ACQUIRE:
    - Timeout goes to UNLOCKED.
    - Line error or frame error resets good_cnt to 0 and stays in ACQUIRE.
    - Frame good increments good_cnt; when the new value equals LOCK_FRAMES, go to LOCKED.
    - Checks apply only in cycles where the state is already ACQUIRE, so the entry edge is not checked.
  - LOCKED:
    - Line error, frame error or timeout goes to UNLOCKED and pulses sync_err on the next cycle.
    - Frame good pulses frame_tick on the next cycle, aligned with rec_x = 0, rec_y = 0.
- Simultaneous events: an error takes priority over frame good in the same cycle.
- locked = (state == LOCKED), registered.
- video_on:
  - Combinational from registered values: locked & H_ACT_START <= rec_x < H_ACT_END & V_ACT_START <= rec_y < V_ACT_END.
  - Forced to 0 whenever not locked.
- Reset mid-frame: everything returns to reset values immediately; reacquisition needs 1 v_rise plus LOCK_FRAMES good frames.
- No internal synchronizers: inputs must come from the same clk domain.

Decomposition:
- Shared package vga_timing_pkg holds H_TOTAL, V_TOTAL, the active-window bounds, and the state encoding (UNLOCKED, ACQUIRE, LOCKED).
- One natural sub-module: sync_edge_det (a register with reset-to-1 plus the rising-edge pulse), instantiated once for h_sync and once for v_sync.
- The bench drives this block from the existing generator.

Test Plan:
- Reset, then drive the generator for 4 frames:
  - locked rises at the first frame_tick after the first v_rise plus 2 good frames.
  - Once locked, rec_x(t+1) == gen pix_x(t) and rec_y(t+1) == gen pix_y(t) every cycle.
  - line_len = 800 and frame_lines = 525.
- Locked run, check video_on:
  - 1 exactly when rec_x is in 144..783 and rec_y is in 35..514.
  - 307200 active cycles per frame.
  - frame_tick occurs once per 420000 clocks.
- Locked, then shorten one line to 799 clocks: sync_err pulses once, locked = 0, line_len = 799; relock after 3 frame starts.
- Locked, then hold h_sync low for 801 clocks: timeout, sync_err pulses, state UNLOCKED, rec_x saturates toward 1023.
- Locked, then send a 524-line frame: frame_lines = 524, sync_err pulses and locked drops at that v_rise.
- Assert rst mid-frame for 3 cycles: all outputs 0; no false edge when h_sync is high at release; relock after 3 v_rises.
